// File: rtl/meteor_pkg.sv
`default_nettype none
// ============================================================================
// meteor_pkg : playfield constants, meteor slot record, spawn decode  (rev 1.0)
// ============================================================================
package meteor_pkg;

  localparam int unsigned Y_MIN        = 32;
  localparam int unsigned Y_MAX        = 473;
  localparam int unsigned X_SPAWN_BASE = 64;

  typedef struct packed {
    logic       alive;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] size;
    logic [2:0] speed;
  } meteor_t;

  // Fresh meteor from the current LFSR word; it enters fully inside the top line.
  function automatic meteor_t spawn_meteor(input logic [15:0] l, input logic [9:0] y_min);
    meteor_t m;
    m.alive = 1'b1;
    m.size  = 10'd8 + {7'd0, l[2:0]};
    m.speed = {1'b0, l[4:3]} + 3'd1;
    m.x     = 10'(X_SPAWN_BASE) + {1'b0, l[15:7]};
    m.y     = y_min + m.size;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meteor_field_if.sv
`default_nettype none
// ============================================================================
// meteor_field_if : game control in, enemy arrays and HUD signals out  (rev 1.0)
// ============================================================================
interface meteor_field_if #(
  parameter int unsigned OBJ_NUM = 4
);
  logic                    run;
  logic                    ship_die;
  logic [OBJ_NUM-1:0][9:0] enemy_x;
  logic [OBJ_NUM-1:0][9:0] enemy_y;
  logic [OBJ_NUM-1:0][9:0] enemy_size;
  logic [OBJ_NUM-1:0]      enemy_alive;
  logic                    score_tick;
  logic [7:0]              spawn_period;

  modport master (
    input  run, ship_die,
    output enemy_x, enemy_y, enemy_size, enemy_alive, score_tick, spawn_period
  );

  modport slave (
    output run, ship_die,
    input  enemy_x, enemy_y, enemy_size, enemy_alive, score_tick, spawn_period
  );
endinterface
`default_nettype wire

// File: rtl/meteor_field_lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16 : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, step on en  (rev 1.0)
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        Reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] r_state;
  logic        w_feedback;

  // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
  assign w_feedback = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
  assign q          = r_state;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= seed;
    end else if (en) begin
      r_state <= {w_feedback, r_state[15:1]};
    end
  end
endmodule
`default_nettype wire

// File: rtl/meteor_field.sv
`default_nettype none
// ============================================================================
// meteor_field : spawns, moves and retires meteorite slots once per frame  (rev 1.0)
// ============================================================================
module meteor_field
  import meteor_pkg::*;
#(
  parameter int unsigned OBJ_NUM      = 4,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned SPAWN_MIN    = 16,
  parameter int unsigned PERIOD_STEP  = 4,
  parameter int unsigned Y_MIN        = meteor_pkg::Y_MIN,
  parameter int unsigned Y_MAX        = meteor_pkg::Y_MAX,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic           frame_clk,
  input  logic           Reset,
  meteor_field_if.master bus
);
  localparam logic [7:0] c_SPAWN_PERIOD = 8'(SPAWN_PERIOD);
  localparam logic [7:0] c_SPAWN_MIN    = 8'(SPAWN_MIN);
  localparam logic [7:0] c_PERIOD_STEP  = 8'(PERIOD_STEP);
  localparam logic [9:0] c_Y_MIN        = 10'(Y_MIN);
  localparam logic [9:0] c_Y_MAX        = 10'(Y_MAX);

  meteor_t            r_slots [OBJ_NUM];
  logic [7:0]         r_spawn_cnt;
  logic [7:0]         r_spawn_period;
  logic [2:0]         r_exit_cnt;
  logic               r_score_tick;

  logic               w_active;
  logic               w_spawn_req;
  logic               w_slot_free;
  logic               w_commit;
  logic               w_wrap;
  logic [OBJ_NUM-1:0] w_grant;
  logic [OBJ_NUM-1:0] w_exit;
  logic [9:0]         w_next_y [OBJ_NUM];
  logic [7:0]         w_exit_num;
  logic [8:0]         w_exit_sum;
  logic [7:0]         w_period_dec;
  logic [7:0]         w_period_next;
  logic [7:0]         w_cnt_inc;
  logic [7:0]         w_cnt_next;
  logic [15:0]        w_lfsr;
  meteor_t            w_new;

  assign w_active    = bus.run & ~bus.ship_die;
  assign w_spawn_req = w_active & (r_spawn_cnt == r_spawn_period - 8'd1);
  assign w_commit    = w_spawn_req & w_slot_free;
  assign w_new       = spawn_meteor(w_lfsr, c_Y_MIN);

  lfsr16 u_lfsr (
    .clk   (frame_clk),
    .Reset (Reset),
    .en    (w_commit),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  // Lowest-index dead slot wins; judged on pre-edge alive so an exiting slot waits a period.
  always_comb begin : free_slot
    w_grant     = '0;
    w_slot_free = 1'b0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      if (!r_slots[i].alive && !w_slot_free) begin
        w_grant[i]  = 1'b1;
        w_slot_free = 1'b1;
      end
    end
  end

  always_comb begin : motion
    w_exit     = '0;
    w_exit_num = '0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      w_next_y[i] = r_slots[i].y + {7'd0, r_slots[i].speed};
      w_exit[i]   = r_slots[i].alive && (w_next_y[i] > c_Y_MAX - r_slots[i].size);
      w_exit_num  = w_exit_num + {7'd0, w_exit[i]};
    end
  end

  // Difficulty ramp: every 8th exit shortens the spawn period down to the floor.
  assign w_exit_sum    = {6'd0, r_exit_cnt} + {1'b0, w_exit_num};
  assign w_wrap        = |w_exit_sum[8:3];
  assign w_period_dec  = ({1'b0, r_spawn_period} >= ({1'b0, c_SPAWN_MIN} + {1'b0, c_PERIOD_STEP}))
                         ? r_spawn_period - c_PERIOD_STEP : c_SPAWN_MIN;
  assign w_period_next = w_wrap ? w_period_dec : r_spawn_period;
  assign w_cnt_inc     = w_spawn_req ? 8'd0 : r_spawn_cnt + 8'd1;
  assign w_cnt_next    = (w_wrap && (w_cnt_inc >= w_period_next)) ? 8'd0 : w_cnt_inc;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        r_slots[i] <= '0;
      end
      r_spawn_cnt    <= 8'd0;
      r_spawn_period <= c_SPAWN_PERIOD;
      r_exit_cnt     <= 3'd0;
      r_score_tick   <= 1'b0;
    end else if (bus.ship_die) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        r_slots[i].alive <= 1'b0;
      end
      r_spawn_cnt  <= 8'd0;
      r_score_tick <= 1'b0;
    end else if (bus.run) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        if (r_slots[i].alive) begin
          if (w_exit[i]) begin
            r_slots[i].alive <= 1'b0;
          end else begin
            r_slots[i].y <= w_next_y[i];
          end
        end else if (w_commit && w_grant[i]) begin
          r_slots[i] <= w_new;
        end
      end
      r_score_tick   <= |w_exit;
      r_exit_cnt     <= w_exit_sum[2:0];
      r_spawn_period <= w_period_next;
      r_spawn_cnt    <= w_cnt_next;
    end else begin
      r_score_tick <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < OBJ_NUM; g++) begin : g_out
      assign bus.enemy_x[g]     = r_slots[g].x;
      assign bus.enemy_y[g]     = r_slots[g].y;
      assign bus.enemy_size[g]  = r_slots[g].size;
      assign bus.enemy_alive[g] = r_slots[g].alive;
    end
  endgenerate

  assign bus.score_tick   = r_score_tick;
  assign bus.spawn_period = r_spawn_period;
endmodule
`default_nettype wire

// File: tb/tb_meteor_field.sv
`default_nettype none
// ============================================================================
// tb_meteor_field : directed frame-by-frame checks of meteor_field  (rev 1.0)
// ============================================================================
module tb_meteor_field;
  logic frame_clk = 1'b0;
  logic Reset;

  meteor_field_if #(.OBJ_NUM(4)) bus ();

  meteor_field #(.OBJ_NUM(4)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int       n_checks = 0;
  int       n_errors = 0;
  int       edge_n   = 0;
  int       exits    = 0;
  logic [3:0] prev_alive = 4'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_period(input int e);
    int p;
    p = 60 - 4 * (e / 8);
    if (p < 16) p = 16;
    return p;
  endfunction

  // One frame: exits are inferred from alive bits falling outside ship_die.
  task automatic tick();
    logic [3:0] fell;
    logic       die_at_edge;
    die_at_edge = bus.ship_die;
    @(posedge frame_clk);
    #1;
    edge_n++;
    fell       = die_at_edge ? 4'd0 : (prev_alive & ~bus.enemy_alive);
    prev_alive = bus.enemy_alive;
    exits     += $countones(fell);
    check_val($sformatf("score_tick e%0d", edge_n), {31'd0, bus.score_tick}, {31'd0, fell != 4'd0});
    check_val($sformatf("spawn_period e%0d", edge_n), {24'd0, bus.spawn_period}, exp_period(exits));
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic restart_tracking();
    edge_n     = 0;
    exits      = 0;
    prev_alive = 4'd0;
  endtask

  task automatic check_slot(input int s, input int al, input int ex, input int ey, input int esz);
    check_val($sformatf("alive[%0d] e%0d", s, edge_n), {31'd0, bus.enemy_alive[s]}, al);
    check_val($sformatf("x[%0d] e%0d", s, edge_n), {22'd0, bus.enemy_x[s]}, ex);
    check_val($sformatf("y[%0d] e%0d", s, edge_n), {22'd0, bus.enemy_y[s]}, ey);
    check_val($sformatf("size[%0d] e%0d", s, edge_n), {22'd0, bus.enemy_size[s]}, esz);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen8;
    seen8        = 1'b0;
    Reset        = 1'b1;
    bus.run      = 1'b1;
    bus.ship_die = 1'b0;
    #12;
    check_val("reset alive", {28'd0, bus.enemy_alive}, 0);
    check_slot(0, 0, 0, 0, 0);
    check_val("reset period", {24'd0, bus.spawn_period}, 60);
    check_val("reset score", {31'd0, bus.score_tick}, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    restart_tracking();

    // First spawn on edge 60 from the seed word 0xACE1
    run_to(59);
    check_val("alive before spawn", {28'd0, bus.enemy_alive}, 0);
    tick();
    check_slot(0, 1, 409, 41, 9);
    check_val("alive e60", {28'd0, bus.enemy_alive}, 4'b0001);

    // run=0 freezes motion and the spawn counter for three frames
    bus.run = 1'b0;
    run_to(63);
    check_slot(0, 1, 409, 41, 9);
    bus.run = 1'b1;
    run_to(123);
    check_slot(1, 1, 236, 40, 8);
    check_val("y0 e123", {22'd0, bus.enemy_y[0]}, 101);
    run_to(183);
    check_slot(2, 1, 406, 40, 8);
    check_val("y0 e183", {22'd0, bus.enemy_y[0]}, 161);
    check_val("y1 e183", {22'd0, bus.enemy_y[1]}, 220);
    check_val("alive e183", {28'd0, bus.enemy_alive}, 4'b0111);

    // ship_die clears slots, holds positions, restarts the spawn counter
    bus.ship_die = 1'b1;
    tick();
    bus.ship_die = 1'b0;
    check_val("alive after die", {28'd0, bus.enemy_alive}, 0);
    check_val("y0 held after die", {22'd0, bus.enemy_y[0]}, 161);
    check_val("x2 held after die", {22'd0, bus.enemy_x[2]}, 406);
    run_to(243);
    check_val("alive e243", {28'd0, bus.enemy_alive}, 0);
    tick();
    check_slot(0, 1, 235, 44, 12);

    // Asynchronous reset mid-frame
    #3;
    Reset = 1'b1;
    #1;
    check_val("async alive", {28'd0, bus.enemy_alive}, 0);
    check_slot(0, 0, 0, 0, 0);
    check_val("async period", {24'd0, bus.spawn_period}, 60);
    check_val("async score", {31'd0, bus.score_tick}, 0);
    #2;
    Reset = 1'b0;
    restart_tracking();

    // Uninterrupted run: full field at edge 480 drops the request
    run_to(479);
    check_val("alive e479", {28'd0, bus.enemy_alive}, 4'b1111);
    tick();
    check_slot(0, 1, 409, 461, 9);
    check_slot(1, 1, 149, 406, 14);
    check_slot(2, 1, 106, 167, 15);
    check_slot(3, 1, 341, 223, 11);
    run_to(483);
    check_slot(0, 1, 409, 464, 9);
    tick();
    check_val("alive0 exit e484", {31'd0, bus.enemy_alive[0]}, 0);
    check_val("y0 held e484", {22'd0, bus.enemy_y[0]}, 464);
    check_val("score e484", {31'd0, bus.score_tick}, 1);
    tick();
    check_val("score e485", {31'd0, bus.score_tick}, 0);
    run_to(539);
    check_val("alive e539", {28'd0, bus.enemy_alive}, 4'b1100);
    tick();
    check_slot(0, 1, 202, 41, 9);
    check_val("exits by e540", exits, 5);

    // Long run for the difficulty ramp
    while (exits < 88 && edge_n < 40000) begin
      tick();
      if (!seen8 && exits >= 8) begin
        seen8 = 1'b1;
        check_val("period after 8 exits", {24'd0, bus.spawn_period}, 56);
      end
    end
    if (exits < 88)
      check_val("exit budget", exits, 88);
    else
      check_val("period saturated", {24'd0, bus.spawn_period}, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
